// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared types and constants for the writeback stage:
//             load funct3 codes, FSM state encoding, default datapath width.
//  Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

  localparam int XLEN_DEFAULT = 32;

  // RV32 load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module   : load_align
//  Purpose  : Combinational load data alignment. Picks the byte/half lane
//             from an aligned memory word and sign- or zero-extends it.
//  Revision : 1.0  initial release
// ============================================================================
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select: byte by full offset, half by offset bit 1 (bit 0 ignored)
  always_comb begin
    w_byte = rdata[7:0];
    case (addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by load code; unknown codes pass the raw word through
  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   result = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, w_half};
      F3_LW:   result = rdata;
      default: result = rdata;
    endcase
  end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : Writeback stage. Retires ALU/CSR results one cycle after
//             acceptance, holds loads until the LSU answers (or times out),
//             and drives the registered regfile write port, which decode
//             also uses as its same-cycle bypass source.
//  Revision : 1.0  initial release
// ============================================================================
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic            ex_wen_i,
  input  logic            ex_is_load_i,
  input  logic [4:0]      ex_rd_id_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [1:0]      ex_addr_lo_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic            lsu_rvalid_i,
  input  logic [XLEN-1:0] lsu_rdata_i,
  output logic            w_en_o,
  output logic [4:0]      rd_id_o,
  output logic [XLEN-1:0] rd_write_data_o,
  output logic            commit_o,
  output logic            pend_valid_o,
  output logic [4:0]      pend_rd_o,
  output logic            err_o
);

  localparam int c_CNT_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);
  // Counter value on the edge that completes LOAD_TIMEOUT waiting cycles
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_e         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [4:0]        r_ld_rd;
  logic              r_ld_wen;
  logic [2:0]        r_ld_funct3;
  logic [1:0]        r_ld_addr_lo;
  logic              r_w_en;
  logic [4:0]        r_rd_id;
  logic [XLEN-1:0]   r_data;
  logic              r_commit;
  logic [4:0]        r_pend_rd;
  logic              r_err;
  logic [XLEN-1:0]   w_aligned;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata   (lsu_rdata_i),
    .funct3  (r_ld_funct3),
    .addr_lo (r_ld_addr_lo),
    .result  (w_aligned)
  );

  // FSM, timeout counter and all registered writeback outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= WB_IDLE;
      r_cnt        <= '0;
      r_ld_rd      <= '0;
      r_ld_wen     <= 1'b0;
      r_ld_funct3  <= '0;
      r_ld_addr_lo <= '0;
      r_w_en       <= 1'b0;
      r_rd_id      <= '0;
      r_data       <= '0;
      r_commit     <= 1'b0;
      r_pend_rd    <= '0;
      r_err        <= 1'b0;
    end else begin
      // Write and commit are single-cycle pulses
      r_w_en   <= 1'b0;
      r_commit <= 1'b0;
      case (r_state)
        WB_IDLE: begin
          if (ex_valid_i) begin
            if (ex_is_load_i) begin
              r_ld_rd      <= ex_rd_id_i;
              r_ld_wen     <= ex_wen_i;
              r_ld_funct3  <= ex_funct3_i;
              r_ld_addr_lo <= ex_addr_lo_i;
              r_pend_rd    <= ex_rd_id_i;
              r_cnt        <= '0;
              r_state      <= WB_WAIT_LOAD;
            end else begin
              r_commit <= 1'b1;
              r_w_en   <= ex_wen_i && (ex_rd_id_i != 5'd0);
              r_rd_id  <= ex_rd_id_i;
              r_data   <= ex_result_i;
            end
          end
        end
        WB_WAIT_LOAD: begin
          // rvalid takes priority over a simultaneous timeout
          if (lsu_rvalid_i) begin
            r_commit  <= 1'b1;
            r_w_en    <= r_ld_wen && (r_ld_rd != 5'd0);
            r_rd_id   <= r_ld_rd;
            r_data    <= w_aligned;
            r_pend_rd <= '0;
            r_state   <= WB_IDLE;
          end else if (r_cnt == c_TMO_LAST) begin
            r_err     <= 1'b1;
            r_pend_rd <= '0;
            r_state   <= WB_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

  // Handshake and pending-load status derive directly from the state register
  always_comb begin
    ex_ready_o   = (r_state == WB_IDLE);
    pend_valid_o = (r_state == WB_WAIT_LOAD);
  end

  assign w_en_o          = r_w_en;
  assign rd_id_o         = r_rd_id;
  assign rd_write_data_o = r_data;
  assign commit_o        = r_commit;
  assign pend_rd_o       = r_pend_rd;
  assign err_o           = r_err;

endmodule : wb_stage
`default_nettype wire
